// File: rtl/ws2811_frame_scheduler.sv
// Frame sequencer for the WS2811 array datapath: arbitrates ext/wave sources,
// walks every LED word, then holds the serial latch gap. Auto-refresh optional.
module ws2811_frame_scheduler #(
  parameter int REFRESH_CYCLES = 1000000,
  parameter int WORD_TIMEOUT   = 4096,
  parameter int TIMER_W        = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_ext,
  input  logic       req_wave,
  input  logic       auto_refresh,
  input  logic       last_led,
  input  logic       word_sent,
  input  logic       serial_reset_done,
  output logic       send_data,
  output logic       next_led,
  output logic       serial_reset,
  output logic       use_external_rgb,
  output logic       grant_ext,
  output logic       grant_wave,
  output logic       busy,
  output logic       frame_done,
  output logic       error,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_WORD = 3'd3,
    S_ADVANCE   = 3'd4,
    S_CHECK     = 3'd5,
    S_LATCH     = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [TIMER_W-1:0] REFRESH_LAST = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WORD_LAST    = TIMER_W'(WORD_TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] refresh_cnt;
  logic [TIMER_W-1:0] timeout_cnt;
  logic               refresh_tick;
  logic               tick_pending;
  logic               rr_ext;
  logic               last_ext;
  logic               pick_ext;
  logic               word_timeout;

  assign refresh_tick = auto_refresh && (refresh_cnt == REFRESH_LAST);
  assign word_timeout = (timeout_cnt == WORD_LAST);

  // Single requester wins outright; a tie goes round-robin; tick-only repeats the last owner.
  always_comb begin
    pick_ext = last_ext;
    if (req_ext && !req_wave)
      pick_ext = 1'b1;
    else if (!req_ext && req_wave)
      pick_ext = 1'b0;
    else if (req_ext && req_wave)
      pick_ext = rr_ext;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (req_ext || req_wave || tick_pending) state_nxt = S_ARB;
      S_ARB:       state_nxt = S_SEND;
      S_SEND:      state_nxt = S_WAIT_WORD;
      S_WAIT_WORD: begin
        if (word_sent)
          state_nxt = S_ADVANCE;
        else if (word_timeout)
          state_nxt = S_LATCH;
      end
      S_ADVANCE:   state_nxt = S_CHECK;
      S_CHECK:     state_nxt = last_led ? S_LATCH : S_SEND;
      S_LATCH:     if (serial_reset_done) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    send_data    = (state == S_SEND);
    next_led     = (state == S_ADVANCE);
    serial_reset = (state == S_LATCH);
    frame_done   = (state == S_DONE);
    busy         = (state != S_IDLE);
    db_estado    = {1'b0, state};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_cnt      <= '0;
      timeout_cnt      <= '0;
      tick_pending     <= 1'b0;
      rr_ext           <= 1'b1;
      last_ext         <= 1'b1;
      grant_ext        <= 1'b0;
      grant_wave       <= 1'b0;
      use_external_rgb <= 1'b0;
      error            <= 1'b0;
    end else begin
      if (!auto_refresh || refresh_tick)
        refresh_cnt <= '0;
      else
        refresh_cnt <= refresh_cnt + TIMER_W'(1);

      // The frame starting in ARB satisfies any tick arriving in that same cycle.
      if (state == S_ARB)
        tick_pending <= 1'b0;
      else if (refresh_tick)
        tick_pending <= 1'b1;

      case (state)
        S_ARB: begin
          grant_ext        <= pick_ext;
          grant_wave       <= !pick_ext;
          use_external_rgb <= pick_ext;
          rr_ext           <= !pick_ext;
          last_ext         <= pick_ext;
        end
        S_SEND: timeout_cnt <= '0;
        S_WAIT_WORD: begin
          if (!word_sent) begin
            if (word_timeout)
              error <= 1'b1;
            else
              timeout_cnt <= timeout_cnt + TIMER_W'(1);
          end
        end
        S_DONE: begin
          grant_ext        <= 1'b0;
          grant_wave       <= 1'b0;
          use_external_rgb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ws2811_frame_scheduler.md
Name: ws2811_frame_scheduler

Overview:
- Control unit that sequences the WS2811 array datapath through whole frames: per-LED word transmission, LED advance, then the serial reset/latch gap.
- Arbitrates strip ownership between two colour sources: the external RGB bank and the internal wave provider.
- Generates periodic auto-refresh frames.
- Sits between game/top-level logic and the array datapath, driving its send/next/serial-reset controls and its source select.

Parameters:
- REFRESH_CYCLES, 1000000, clock cycles between auto-refresh ticks (50 Hz at 50 MHz).
- WORD_TIMEOUT, 4096, maximum cycles in WAIT_WORD before the frame is aborted.
- TIMER_W, 32, width of the refresh and timeout counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_ext  in  1  level request for a frame from the external RGB bank
- req_wave  in  1  level request for a frame from the wave provider
- auto_refresh  in  1  enables periodic refresh frames
- last_led  in  1  datapath condition: LED index has reached the configured count
- word_sent  in  1  datapath condition: 24-bit word finished
- serial_reset_done  in  1  datapath condition: latch gap elapsed
- send_data  out  1  one-cycle pulse that starts a word
- next_led  out  1  one-cycle pulse that advances the LED index
- serial_reset  out  1  held high during the latch gap; also clears the LED index
- use_external_rgb  out  1  source select, registered, stable for the whole frame
- grant_ext  out  1  external source owns the current frame
- grant_wave  out  1  wave source owns the current frame
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- error  out  1  sticky word-timeout flag
- db_estado  out  4  current state encoding, for debug

Behaviour:
- Reset values:
  - All outputs 0 and state IDLE.
  - Round-robin pointer favours ext; pending tick cleared; both timers cleared.
  - Reset mid-frame abandons the frame immediately; no frame_done is produced.
- States and encoding: IDLE=0, ARB=1, SEND=2, WAIT_WORD=3, ADVANCE=4, CHECK=5, LATCH=6, DONE=7.
- IDLE:
  - Leave to ARB when req_ext, req_wave, or the pending tick is set.
  - Otherwise stay.
- ARB (one cycle):
  - Grant selection:
    - Only one request asserted: that source wins.
    - Both asserted: the source not granted last wins (round-robin).
    - No request (tick only): reuse the last granted source.
  - Register grant_* and use_external_rgb, clear the pending tick, go to SEND.
  - Grants hold until DONE.
- SEND: send_data=1 for exactly one cycle, clear the timeout counter, go to WAIT_WORD.
- WAIT_WORD:
  - word_sent seen → ADVANCE.
  - Timeout counter reaches WORD_TIMEOUT−1 → set error, go to LATCH (abort).
- ADVANCE: next_led=1 for exactly one cycle, go to CHECK.
- CHECK:
  - Evaluate last_led one cycle after the advance, so the updated index is seen.
  - last_led=1 → LATCH; otherwise → SEND.
- LATCH: serial_reset=1 every cycle until serial_reset_done is sampled high, then go to DONE.
- DONE:
  - frame_done=1 for one cycle; grants and use_external_rgb drop to 0; go to IDLE.
  - Minimum frame for one LED: ARB, SEND, WAIT_WORD(≥1), ADVANCE, CHECK, LATCH(≥1), DONE.
- Refresh timer:
  - Free-running while auto_refresh=1; cleared and held while auto_refresh=0.
  - Ticks at count REFRESH_CYCLES−1, then wraps to 0.
  - Tick while busy: set the pending flag (at most one pending; further ticks are absorbed).
  - Tick in the same cycle as ARB: the ARB clear wins, so that tick is discarded, since the frame just started satisfies it.
- Requests are levels: a requester holding its request gets back-to-back frames, alternating with the other requester when both are asserted.
- Requests that drop before ARB are not remembered.
- error is cleared only by reset.
- serial_reset, send_data and next_led are never high in the same cycle.

Test Plan:
- Datapath model: word_sent 30 cycles after send_data; last_led when the index ≥3; serial_reset_done after 100 cycles of serial_reset. Pulse req_ext → exactly 3 send_data and 3 next_led pulses, then serial_reset held about 100 cycles, one frame_done; use_external_rgb=1 throughout; busy falls the cycle after DONE.
- req_ext and req_wave both held high → grants alternate ext, wave, ext across three consecutive frames; use_external_rgb toggles 1, 0, 1.
- Reduce REFRESH_CYCLES to 500 with auto_refresh=1 and no requests → frames start every ≥500 cycles; grant repeats the last granted source (ext after reset).
- word_sent tied low → after 4096 WAIT_WORD cycles, error=1 and LATCH is entered; frame_done still pulses; error stays high through the next normal frame.
- Assert reset during WAIT_WORD of LED 2 → all outputs 0 and state IDLE immediately, with no frame_done; the next request runs a full 3-LED frame.
- Refresh tick during a busy frame, then a further tick in the same frame → exactly one extra frame starts after DONE.
